ex_mem_skid: RTL and testbench
==============================

Name: ex_mem_skid

Overview:
- Pipeline boundary between the EX stage and the MEM stage.
- Consumes the EX result bundle with a valid/ready handshake and presents it to MEM with a valid/ready handshake.
- Holds a 2-entry skid buffer, so a multi-cycle MEM access (memory/UART controller busy) stalls EX without losing the in-flight result.
- Supports a synchronous flush from the branch/exception control.

Parameters:
- XLEN, 32, width of data and address fields
- REG_ADDR_W, 5, destination register index width
- MEMOP_W, 4, memory operation code width (load/store kind and size)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered entries
- in_valid  in  1  EX presents a bundle
- in_ready  out  1  block can accept a bundle this cycle
- in_memop  in  MEMOP_W  memory op, 0 = no memory access
- in_addr  in  XLEN  effective address
- in_sdata  in  XLEN  store data
- in_wd  in  REG_ADDR_W  destination register
- in_wreg  in  1  register write enable
- in_wdata  in  XLEN  ALU result / writeback data
- out_valid  out  1  bundle presented to MEM
- out_ready  in  1  MEM accepts the bundle this cycle
- out_memop  out  MEMOP_W  buffered memop
- out_addr  out  XLEN  buffered address
- out_sdata  out  XLEN  buffered store data
- out_wd  out  REG_ADDR_W  buffered destination register
- out_wreg  out  1  buffered write enable
- out_wdata  out  XLEN  buffered writeback data

Behaviour:
- Storage is two payload registers: main (drives out_*) and skid.
- State is EMPTY, ONE (main valid) or TWO (main and skid valid).
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- in_ready = (state != TWO). It is decoded from registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Reset:
  - state <= EMPTY.
  - All main and skid payload fields <= 0.
  - Hence after reset: out_valid=0, all out_* = 0, in_ready=1.
  - in_valid is ignored in the reset cycle.
- Transitions (evaluated at posedge when not rst and not flush):
  - EMPTY, in_fire -> ONE, main <= in.
  - EMPTY, no in_fire -> EMPTY.
  - ONE, in_fire & out_fire -> ONE, main <= in.
  - ONE, in_fire & !out_fire -> TWO, skid <= in, main holds.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> ONE, hold.
  - TWO, out_fire -> ONE, main <= skid.
  - TWO, no out_fire -> TWO, hold.
  - in_fire cannot occur in TWO because in_ready=0.
- Flush:
  - Priority: rst > flush > handshakes.
  - On flush: state <= EMPTY and main/skid payloads <= 0.
  - An in_fire coinciding with flush counts as consumed upstream and is discarded.
  - An out_fire coinciding with flush counts as completed by MEM.
- Latency: a bundle accepted at edge N appears on out_* at edge N+1 (1 cycle) when the block is not backpressured.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Stability: while out_valid=1 and out_ready=0, all out_* stay constant.
- Payload: passed bit-exact, with no arithmetic. out_* values are don't-care when out_valid=0, except after reset or flush, when they are 0.
- Throughput: one bundle per cycle while out_ready=1.

Decomposition:
- Shared defines file:
  - MemOpBus, RegBus and RegAddrBus widths.
  - MEMOP_NONE = 0.
  - RstEnable.
- Sub-module skid_payload_reg: one payload register (all fields) with load, clear and hold. It is instantiated twice, for main and skid.
- The state FSM stays in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, out_wdata=0, in_ready=1, and nothing captured.
- Pass-through: out_ready=1; send wd=5, wreg=1, wdata=0x12345678, then wd=6, wdata=0xCAFEBABE on consecutive cycles -> each appears exactly 1 cycle later, in_ready stays 1, and no bubbles occur.
- Backpressure:
  - Setup: out_ready=0; send A (wdata=0x1) then B (wdata=0x2).
  - Expected: state TWO, in_ready=0, out_wdata=0x1 held.
  - Then: raise out_ready for 2 cycles -> out shows 0x1, then 0x2, then out_valid=0.
- Simultaneous in/out in ONE: main=0xA, in_valid=1 with 0xB, out_ready=1 -> next cycle out_wdata=0xB, state ONE, no skid use.
- Flush in TWO with in_valid=1 and out_ready=0 -> next cycle out_valid=0, in_ready=1, out_* = 0. A following bundle 0x77 emerges alone.
- Random stress over 10k cycles with random in_valid/out_ready/flush (flush 2%) -> a scoreboard confirms no loss, no duplication and preserved order, with all entries between flushes accounted for.

Source files
------------

// File: rtl/ex_mem_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_skid_pkg
// Description : Shared widths, constants and state encoding for the EX/MEM
//               skid-buffered pipeline boundary.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_skid_pkg;

  // Bus widths shared by the EX and MEM stages
  localparam int MEM_OP_BUS_W   = 4;   // MemOpBus
  localparam int REG_BUS_W      = 32;  // RegBus
  localparam int REG_ADDR_BUS_W = 5;   // RegAddrBus

  // Memory op code meaning "no memory access"
  localparam logic [MEM_OP_BUS_W-1:0] MEMOP_NONE = '0;

  // Active level of the synchronous reset
  localparam logic RST_ENABLE = 1'b1;

  // Occupancy of the two-entry buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing buffered
    ST_ONE   = 2'd1,  // main valid
    ST_TWO   = 2'd2   // main and skid valid
  } skid_state_e;

endpackage : ex_mem_skid_pkg
`default_nettype wire

// File: rtl/ex_mem_skid_payload_reg.sv
`default_nettype none
// ============================================================================
// Module      : skid_payload_reg
// Description : One EX->MEM payload register holding every bundle field.
//               Reset and clear zero the contents, load captures d_*,
//               otherwise the contents hold.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               clear              - synchronous zeroing (flush)
//               load               - capture d_* this cycle
//               d_*                - incoming bundle fields
//               q_*                - stored bundle fields
// Revision    : 1.0 - initial release
// ============================================================================
module skid_payload_reg
  import ex_mem_skid_pkg::*;
#(
  parameter int XLEN       = REG_BUS_W,
  parameter int REG_ADDR_W = REG_ADDR_BUS_W,
  parameter int MEMOP_W    = MEM_OP_BUS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [MEMOP_W-1:0]    d_memop,
  input  logic [XLEN-1:0]       d_addr,
  input  logic [XLEN-1:0]       d_sdata,
  input  logic [REG_ADDR_W-1:0] d_wd,
  input  logic                  d_wreg,
  input  logic [XLEN-1:0]       d_wdata,
  output logic [MEMOP_W-1:0]    q_memop,
  output logic [XLEN-1:0]       q_addr,
  output logic [XLEN-1:0]       q_sdata,
  output logic [REG_ADDR_W-1:0] q_wd,
  output logic                  q_wreg,
  output logic [XLEN-1:0]       q_wdata
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clear) begin
      q_memop <= MEMOP_W'(MEMOP_NONE);
      q_addr  <= '0;
      q_sdata <= '0;
      q_wd    <= '0;
      q_wreg  <= 1'b0;
      q_wdata <= '0;
    end else if (load) begin
      q_memop <= d_memop;
      q_addr  <= d_addr;
      q_sdata <= d_sdata;
      q_wd    <= d_wd;
      q_wreg  <= d_wreg;
      q_wdata <= d_wdata;
    end
  end

endmodule : skid_payload_reg
`default_nettype wire

// File: rtl/ex_mem_skid.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_skid
// Description : EX->MEM pipeline boundary with a 2-entry skid buffer.
//               'main' drives the out_* bundle; 'skid' catches the bundle
//               accepted in the cycle MEM stalls. in_ready depends only on
//               registered state, so there is no combinational path from
//               out_ready to in_ready.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               flush               - discard all buffered entries
//               in_valid/in_ready   - EX-side handshake
//               in_*                - EX result bundle
//               out_valid/out_ready - MEM-side handshake
//               out_*               - bundle presented to MEM
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int XLEN       = REG_BUS_W,
  parameter int REG_ADDR_W = REG_ADDR_BUS_W,
  parameter int MEMOP_W    = MEM_OP_BUS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MEMOP_W-1:0]    in_memop,
  input  logic [XLEN-1:0]       in_addr,
  input  logic [XLEN-1:0]       in_sdata,
  input  logic [REG_ADDR_W-1:0] in_wd,
  input  logic                  in_wreg,
  input  logic [XLEN-1:0]       in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MEMOP_W-1:0]    out_memop,
  output logic [XLEN-1:0]       out_addr,
  output logic [XLEN-1:0]       out_sdata,
  output logic [REG_ADDR_W-1:0] out_wd,
  output logic                  out_wreg,
  output logic [XLEN-1:0]       out_wdata
);

  skid_state_e r_state;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_load;
  logic w_skid_load;
  logic w_main_from_skid;

  logic [MEMOP_W-1:0]    w_skid_memop;
  logic [XLEN-1:0]       w_skid_addr;
  logic [XLEN-1:0]       w_skid_sdata;
  logic [REG_ADDR_W-1:0] w_skid_wd;
  logic                  w_skid_wreg;
  logic [XLEN-1:0]       w_skid_wdata;

  logic [MEMOP_W-1:0]    w_main_d_memop;
  logic [XLEN-1:0]       w_main_d_addr;
  logic [XLEN-1:0]       w_main_d_sdata;
  logic [REG_ADDR_W-1:0] w_main_d_wd;
  logic                  w_main_d_wreg;
  logic [XLEN-1:0]       w_main_d_wdata;

  // Handshake decode from registered state only
  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // main refills from skid when draining TWO, otherwise from EX.
  // skid only loads when ONE receives a bundle while MEM stalls.
  assign w_main_from_skid = (r_state == ST_TWO);
  assign w_main_load = ((r_state == ST_EMPTY) & w_in_fire)
                     | ((r_state == ST_ONE) & w_in_fire & w_out_fire)
                     | ((r_state == ST_TWO) & w_out_fire);
  assign w_skid_load = (r_state == ST_ONE) & w_in_fire & ~w_out_fire;

  assign w_main_d_memop = w_main_from_skid ? w_skid_memop : in_memop;
  assign w_main_d_addr  = w_main_from_skid ? w_skid_addr  : in_addr;
  assign w_main_d_sdata = w_main_from_skid ? w_skid_sdata : in_sdata;
  assign w_main_d_wd    = w_main_from_skid ? w_skid_wd    : in_wd;
  assign w_main_d_wreg  = w_main_from_skid ? w_skid_wreg  : in_wreg;
  assign w_main_d_wdata = w_main_from_skid ? w_skid_wdata : in_wdata;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      r_state <= ST_TWO;
          else if (!w_in_fire && w_out_fire) r_state <= ST_EMPTY;
        end
        ST_TWO:   if (w_out_fire) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  skid_payload_reg #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W),
    .MEMOP_W    (MEMOP_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .load    (w_main_load),
    .d_memop (w_main_d_memop),
    .d_addr  (w_main_d_addr),
    .d_sdata (w_main_d_sdata),
    .d_wd    (w_main_d_wd),
    .d_wreg  (w_main_d_wreg),
    .d_wdata (w_main_d_wdata),
    .q_memop (out_memop),
    .q_addr  (out_addr),
    .q_sdata (out_sdata),
    .q_wd    (out_wd),
    .q_wreg  (out_wreg),
    .q_wdata (out_wdata)
  );

  skid_payload_reg #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W),
    .MEMOP_W    (MEMOP_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .load    (w_skid_load),
    .d_memop (in_memop),
    .d_addr  (in_addr),
    .d_sdata (in_sdata),
    .d_wd    (in_wd),
    .d_wreg  (in_wreg),
    .d_wdata (in_wdata),
    .q_memop (w_skid_memop),
    .q_addr  (w_skid_addr),
    .q_sdata (w_skid_sdata),
    .q_wd    (w_skid_wd),
    .q_wreg  (w_skid_wreg),
    .q_wdata (w_skid_wdata)
  );

endmodule : ex_mem_skid
`default_nettype wire

// File: tb/tb_ex_mem_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_skid
// Description : Self-checking bench for ex_mem_skid. A two-deep queue model
//               tracks accepted bundles; every cycle the DUT handshake and
//               head-of-queue payload are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_skid;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int MOW  = 4;
  localparam int PW   = MOW + XLEN + XLEN + RAW + 1 + XLEN;  // 106

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [MOW-1:0]  in_memop = '0;
  logic [XLEN-1:0] in_addr = '0;
  logic [XLEN-1:0] in_sdata = '0;
  logic [RAW-1:0]  in_wd = '0;
  logic            in_wreg = 1'b0;
  logic [XLEN-1:0] in_wdata = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [MOW-1:0]  out_memop;
  logic [XLEN-1:0] out_addr;
  logic [XLEN-1:0] out_sdata;
  logic [RAW-1:0]  out_wd;
  logic            out_wreg;
  logic [XLEN-1:0] out_wdata;

  ex_mem_skid #(.XLEN(XLEN), .REG_ADDR_W(RAW), .MEMOP_W(MOW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_memop  (in_memop),
    .in_addr   (in_addr),
    .in_sdata  (in_sdata),
    .in_wd     (in_wd),
    .in_wreg   (in_wreg),
    .in_wdata  (in_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_memop (out_memop),
    .out_addr  (out_addr),
    .out_sdata (out_sdata),
    .out_wd    (out_wd),
    .out_wreg  (out_wreg),
    .out_wdata (out_wdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO of accepted bundles, capacity two
  logic [PW-1:0] model_q[$];
  logic          model_zero = 1'b0;  // payload known zero (after reset/flush)
  int            n_delivered = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_bundle();
    return {MOW'($urandom), $urandom, $urandom, RAW'($urandom), 1'($urandom), $urandom};
  endfunction

  function automatic logic [PW-1:0] mk(input logic [RAW-1:0] wd, input logic wreg,
                                      input logic [XLEN-1:0] wdata);
    return {MOW'(0), 32'h0, 32'h0, wd, wreg, wdata};
  endfunction

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic step(input logic r, input logic fl, input logic v,
                      input logic [PW-1:0] b, input logic ordy);
    bit in_f, out_f;
    rst = r;
    flush = fl;
    in_valid = v;
    out_ready = ordy;
    {in_memop, in_addr, in_sdata, in_wd, in_wreg, in_wdata} = b;
    in_f  = v && (model_q.size() < 2);
    out_f = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (r || fl) begin
      if (!r && out_f) n_delivered++;
      model_q.delete();
      model_zero = 1'b1;
    end else begin
      if (out_f) begin
        void'(model_q.pop_front());
        n_delivered++;
      end
      if (in_f) begin
        model_q.push_back(b);
        model_zero = 1'b0;
      end
    end
    #1;
    check("in_ready", 128'(in_ready), 128'(model_q.size() < 2));
    check("out_valid", 128'(out_valid), 128'(model_q.size() > 0));
    if (model_q.size() > 0)
      check("payload", 128'({out_memop, out_addr, out_sdata, out_wd, out_wreg, out_wdata}),
            128'(model_q[0]));
    else if (model_zero)
      check("zero_payload", 128'({out_memop, out_addr, out_sdata, out_wd, out_wreg, out_wdata}),
            128'(0));
  endtask

  initial begin
    logic [PW-1:0] b;
    int delivered_before;

    // Reset for two cycles with in_valid high: nothing captured
    step(1'b1, 1'b0, 1'b1, mk(5'd3, 1'b1, 32'hDEAD), 1'b0);
    step(1'b1, 1'b0, 1'b1, mk(5'd3, 1'b1, 32'hDEAD), 1'b0);
    check("rst_out_wdata", 128'(out_wdata), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // Pass-through: each bundle visible one cycle later, no bubbles
    step(1'b0, 1'b0, 1'b1, mk(5'd5, 1'b1, 32'h12345678), 1'b1);
    check("pt_first", 128'(out_wdata), 128'(32'h12345678));
    step(1'b0, 1'b0, 1'b1, mk(5'd6, 1'b1, 32'hCAFEBABE), 1'b1);
    check("pt_second", 128'({out_wd, out_wdata}), 128'({5'd6, 32'hCAFEBABE}));
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Backpressure: fill both entries, then drain in order
    step(1'b0, 1'b0, 1'b1, mk(5'd1, 1'b1, 32'h1), 1'b0);
    step(1'b0, 1'b0, 1'b1, mk(5'd2, 1'b1, 32'h2), 1'b0);
    check("bp_full_ready", 128'(in_ready), 128'(0));
    check("bp_hold", 128'(out_wdata), 128'(32'h1));
    step(1'b0, 1'b0, 1'b1, mk(5'd9, 1'b1, 32'h9), 1'b0);  // refused: full
    check("bp_still_hold", 128'(out_wdata), 128'(32'h1));
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("bp_drain1", 128'(out_wdata), 128'(32'h2));
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("bp_empty", 128'(out_valid), 128'(0));

    // Simultaneous in/out while holding one entry
    step(1'b0, 1'b0, 1'b1, mk(5'd10, 1'b1, 32'hA), 1'b0);
    step(1'b0, 1'b0, 1'b1, mk(5'd11, 1'b1, 32'hB), 1'b1);
    check("sim_out", 128'(out_wdata), 128'(32'hB));
    check("sim_no_skid", 128'(in_ready), 128'(1));

    // Flush while full, with in_valid high and MEM stalled
    step(1'b0, 1'b0, 1'b1, mk(5'd12, 1'b1, 32'hC), 1'b0);
    step(1'b0, 1'b1, 1'b1, mk(5'd13, 1'b1, 32'hD), 1'b0);
    check("fl_valid", 128'(out_valid), 128'(0));
    check("fl_wdata", 128'(out_wdata), 128'(0));
    step(1'b0, 1'b0, 1'b1, mk(5'd7, 1'b1, 32'h77), 1'b0);
    check("fl_next", 128'(out_wdata), 128'(32'h77));
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("fl_alone", 128'(out_valid), 128'(0));

    // Random stress
    delivered_before = n_delivered;
    for (int i = 0; i < 10000; i++) begin
      b = rand_bundle();
      step(1'b0, ($urandom_range(99) < 2), ($urandom_range(99) < 65), b,
           ($urandom_range(99) < 60));
    end
    check("stress_progress", 128'(n_delivered > delivered_before + 1000), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ex_mem_skid
`default_nettype wire
